adder_8bit_unit: RTL and testbench
==================================

Name: adder_8bit_unit

Overview:
- 8-bit binary adder with carry-in and carry-out, used as an arithmetic leaf in the datapath.
- Provides a purely combinational sum path for same-cycle consumers.
- Provides a single registered output stage, with valid and signed-overflow flags, for pipelined consumers.
- Internally built as a two-level carry-lookahead adder, not an inferred "+" operator.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of GROUP.
- GROUP, 4, carry-lookahead group size in bits.

Ports:
- clk  input  1  clock; all registered outputs update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned (also read as two's complement for the overflow flag).
- b  input  WIDTH  operand B, same encoding as a.
- carry_in  input  1  carry into bit 0.
- in_valid  input  1  qualifies a, b and carry_in for the registered stage.
- sum  output  WIDTH  combinational sum bits.
- carry_out  output  1  combinational carry out of the MSB.
- sum_q  output  WIDTH  registered sum.
- carry_out_q  output  1  registered carry out.
- overflow_q  output  1  registered signed (two's-complement) overflow.
- out_valid  output  1  registered valid for sum_q, carry_out_q and overflow_q.

Behaviour:
- Combinational path:
  - {carry_out, sum} equals a + b + carry_in, computed at WIDTH+1 bits; no truncation of the carry.
  - Independent of clk, rst and in_valid; settles within the same time step as an input change.
- Carry structure:
  - Per bit: g = a&b, p = a^b.
  - Per group: G and P computed, with group-level lookahead producing each group's carry-in from carry_in.
  - Within a group, bit carries come from the lookahead equations; sum[i] = p[i] ^ c[i].
  - carry_out is the carry out of the top group.
- Wrap-around: 255+1+0 gives sum=0, carry_out=1; 255+255+1 gives sum=255, carry_out=1 (maximum result 511).
- Signed overflow:
  - ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
  - carry_in contributes through sum.
- Registered stage:
  - On a rising clk edge with in_valid=1: sum_q <= sum, carry_out_q <= carry_out, overflow_q <= ovf, out_valid <= 1.
  - On a rising edge with in_valid=0: out_valid <= 0; the data registers hold their previous values.
  - Latency is exactly 1 cycle; throughput is one operation per cycle; there is no back-pressure.
- Reset:
  - rst=1 immediately, without waiting for a clock edge, forces sum_q=0, carry_out_q=0, overflow_q=0, out_valid=0.
  - These values hold while rst is asserted.
  - Reset mid-operation discards the in-flight result.
  - The first capture occurs on the first rising edge with rst=0 and in_valid=1.
  - The combinational outputs are unaffected by rst.
- X/Z on any input bit propagates to the affected outputs; no masking.

Test Plan:
- Combinational, 10 time units per vector, check {carry_out,sum}:
  - 0+0+0 -> 0;
  - 5+3+0 -> 8;
  - 255+1+0 -> 256 (sum=0, carry_out=1);
  - 128+128+0 -> 256 (sum=0, carry_out=1);
  - 100+50+1 -> 151.
- Full carry chain:
  - 255+0+1 -> sum=0, carry_out=1;
  - 255+255+1 -> 511;
  - exhaustive or 10k random a, b, carry_in against a 9-bit reference sum, zero mismatches.
- Registered path:
  - drive in_valid=1 with 100+50+1, then in_valid=0;
  - next edge -> sum_q=151, carry_out_q=0, overflow_q=1, out_valid=1;
  - following edge -> out_valid=0, sum_q still 151.
- Overflow flag:
  - 127+1+0 -> overflow_q=1;
  - 128+128+0 -> overflow_q=1, carry_out_q=1;
  - 5+3+0 -> overflow_q=0;
  - 255+1+0 -> overflow_q=0.
- Async reset:
  - after a valid capture, assert rst between clock edges;
  - all registered outputs go to 0 immediately;
  - combinational sum is unchanged;
  - after release, the next in_valid capture appears exactly 1 cycle later.
- Back-to-back:
  - in_valid=1 for 3 cycles with 5+3, 255+1, 0+0;
  - outputs 8, 256, 0 on consecutive cycles with out_valid continuously 1.

Source files
------------

// File: rtl/adder_8bit_unit.sv
// Carry-lookahead adder leaf: combinational sum/carry plus one registered stage
// carrying the sum, carry, signed-overflow flag and a valid qualifier.
module adder_8bit_unit #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q,
  output logic             overflow_q,
  output logic             out_valid
);

  localparam int NGRP = WIDTH / GROUP;

  // Flattened lookahead: carry out of the low n positions as a sum of products
  // of generate/propagate terms and the incoming carry, with no ripple chain.
  function automatic logic lookahead(input logic [WIDTH-1:0] gv,
                                     input logic [WIDTH-1:0] pv,
                                     input logic             cin,
                                     input int               n);
    logic acc;
    logic prod;
    acc = cin;
    for (int k = 0; k < n; k++) acc = acc & pv[k];
    for (int j = 0; j < n; j++) begin
      prod = gv[j];
      for (int k = j + 1; k < n; k++) prod = prod & pv[k];
      acc = acc | prod;
    end
    return acc;
  endfunction

  function automatic logic signed_ovf(input logic signed [WIDTH-1:0] x,
                                      input logic signed [WIDTH-1:0] y,
                                      input logic signed [WIDTH-1:0] s);
    return ((x < 0) == (y < 0)) && ((s < 0) != (x < 0));
  endfunction

  logic [WIDTH-1:0] g_p0;
  logic [WIDTH-1:0] p_p0;
  logic [WIDTH-1:0] c_p0;
  logic [NGRP-1:0]  grp_g_p0;
  logic [NGRP-1:0]  grp_p_p0;
  logic [NGRP:0]    grp_c_p0;
  logic             ovf_p0;

  always_comb begin
    g_p0     = a & b;
    p_p0     = a ^ b;
    grp_g_p0 = '0;
    grp_p_p0 = '0;
    grp_c_p0 = '0;
    c_p0     = '0;
    for (int k = 0; k < NGRP; k++) begin
      grp_g_p0[k] = lookahead(g_p0 >> (k * GROUP), p_p0 >> (k * GROUP), 1'b0, GROUP);
      grp_p_p0[k] = &p_p0[k*GROUP +: GROUP];
    end
    for (int k = 0; k <= NGRP; k++)
      grp_c_p0[k] = lookahead(WIDTH'(grp_g_p0), WIDTH'(grp_p_p0), carry_in, k);
    for (int k = 0; k < NGRP; k++)
      for (int j = 0; j < GROUP; j++)
        c_p0[k*GROUP + j] = lookahead(g_p0 >> (k * GROUP), p_p0 >> (k * GROUP),
                                      grp_c_p0[k], j);
  end

  assign sum       = p_p0 ^ c_p0;
  assign carry_out = grp_c_p0[NGRP];
  assign ovf_p0    = signed_ovf(a, b, sum);

  // ---- stage p0 -> p1 ----
  logic [WIDTH-1:0] sum_p1;
  logic             carry_p1;
  logic             ovf_p1;
  logic             vld_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p1   <= '0;
      carry_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1   <= sum;
        carry_p1 <= carry_out;
        ovf_p1   <= ovf_p0;
      end
    end
  end

  assign sum_q       = sum_p1;
  assign carry_out_q = carry_p1;
  assign overflow_q  = ovf_p1;
  assign out_valid   = vld_p1;

endmodule

// File: tb/tb_adder_8bit_unit.sv
// Directed and random checks of the combinational and registered adder paths.
module tb_adder_8bit_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       carry_in = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] sum;
  logic       carry_out;
  logic [7:0] sum_q;
  logic       carry_out_q;
  logic       overflow_q;
  logic       out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  adder_8bit_unit #(.WIDTH(8), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in), .in_valid(in_valid),
    .sum(sum), .carry_out(carry_out), .sum_q(sum_q), .carry_out_q(carry_out_q),
    .overflow_q(overflow_q), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({sum_q, carry_out_q, overflow_q, out_valid} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected 0", {sum_q, carry_out_q, overflow_q, out_valid});
    end
    a = 8'd7; b = 8'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, carry_out_q, overflow_q, out_valid} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h expected 0", {sum_q, carry_out_q, overflow_q, out_valid});
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_comb();
    logic [7:0] va [7]  = '{8'd0, 8'd5, 8'd255, 8'd128, 8'd100, 8'd255, 8'd255};
    logic [7:0] vb [7]  = '{8'd0, 8'd3, 8'd1,   8'd128, 8'd50,  8'd0,   8'd255};
    logic       vc [7]  = '{1'b0, 1'b0, 1'b0,  1'b0,   1'b1,   1'b1,   1'b1};
    logic [8:0] exp [7] = '{9'd0, 9'd8, 9'd256, 9'd256, 9'd151, 9'd256, 9'd511};
    for (int i = 0; i < 7; i++) begin
      a = va[i]; b = vb[i]; carry_in = vc[i];
      #10;
      n_cmp++;
      if ({carry_out, sum} !== exp[i]) begin
        n_bad++;
        $display("FAIL comb_vec%0d: got %0d expected %0d", i, {carry_out, sum}, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] ref_sum;
    int bad_here = 0;
    for (int i = 0; i < 10000; i++) begin
      a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
      ref_sum = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
      #1;
      n_cmp++;
      if ({carry_out, sum} !== ref_sum) begin
        n_bad++;
        if (bad_here < 5)
          $display("FAIL rand_%0d+%0d+%0d: got %0d expected %0d", a, b, carry_in, {carry_out, sum}, ref_sum);
        bad_here++;
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a = 8'd100; b = 8'd50; carry_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, carry_out_q, overflow_q, out_valid} !== {8'd151, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL reg_capture: got sum_q=%0d co=%b ovf=%b vld=%b expected 151 0 1 1",
               sum_q, carry_out_q, overflow_q, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0; a = 8'd1; b = 8'd2; carry_in = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, out_valid} !== {8'd151, 1'b0}) begin
      n_bad++;
      $display("FAIL reg_hold: got sum_q=%0d vld=%b expected 151 0", sum_q, out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] va [4] = '{8'd127, 8'd128, 8'd5, 8'd255};
    logic [7:0] vb [4] = '{8'd1,   8'd128, 8'd3, 8'd1};
    logic [9:0] exp [4] = '{{8'd128, 1'b0, 1'b1}, {8'd0, 1'b1, 1'b1},
                            {8'd8,   1'b0, 1'b0}, {8'd0, 1'b1, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; carry_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({sum_q, carry_out_q, overflow_q} !== exp[i]) begin
        n_bad++;
        $display("FAIL ovf_vec%0d: got sum_q=%0d co=%b ovf=%b expected %0d %b %b",
                 i, sum_q, carry_out_q, overflow_q, exp[i][9:2], exp[i][1], exp[i][0]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 8'd100; b = 8'd50; carry_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sum_q, carry_out_q, overflow_q, out_valid} !== 11'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %h expected 0", {sum_q, carry_out_q, overflow_q, out_valid});
    end
    n_cmp++;
    if ({carry_out, sum} !== 9'd151) begin
      n_bad++;
      $display("FAIL comb_during_reset: got %0d expected 151", {carry_out, sum});
    end
    @(negedge clk);
    rst = 1'b0; a = 8'd5; b = 8'd3; carry_in = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_release_early: got vld=%b expected 0", out_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, out_valid} !== {8'd8, 1'b1}) begin
      n_bad++;
      $display("FAIL post_release_capture: got sum_q=%0d vld=%b expected 8 1", sum_q, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'd5, 8'd255, 8'd0};
    logic [7:0] vb [3] = '{8'd3, 8'd1,   8'd0};
    logic [8:0] exp [3] = '{9'd8, 9'd256, 9'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; carry_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({carry_out_q, sum_q, out_valid} !== {exp[i], 1'b1}) begin
        n_bad++;
        $display("FAIL b2b_%0d: got %0d vld=%b expected %0d vld=1",
                 i, {carry_out_q, sum_q}, out_valid, exp[i]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_comb();
    test_random();
    test_registered();
    test_overflow();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
